regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_clear_fsm.sv | 49 ++++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Optional write-to-read bypass is enabled by defining REGFILE_MP_BYPASS_EN.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks an index from 1 to DEPTH-1 after reset, holding busy high.
// Register 0 is never stored, so the walk starts at 1.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_idx   <= FIRST_IDX;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // The index saturates at LAST_IDX; READY is left only through rst.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        if (r_state == ST_CLEAR) begin
            if (r_idx == LAST_IDX) begin
                w_state_next = ST_READY;
            end else begin
                w_idx_next = r_idx + FIRST_IDX;
            end
        end
    end

    assign busy    = (r_state == ST_CLEAR);
    assign clr_idx = r_idx;

endmodule

// File: rtl/regfile_mp.sv
// Two-read / two-write register file with hardwired zero register and a post-reset clear walk.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int N     = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd0,
    input  logic [AW-1:0] rd1,
    input  logic [N-1:0]  wd0,
    input  logic [N-1:0]  wd1,
    input  logic          we0,
    input  logic          we1,
    output logic [N-1:0]  read_data1,
    output logic [N-1:0]  read_data2,
    output logic          busy
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic          w_busy;
    logic [AW-1:0] w_clr_idx;
    logic          w_wen0;
    logic          w_wen1;
    logic [AW-1:0] w_rs [2];
    logic [N-1:0]  r_mem [DEPTH];

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk     (clk),
        .rst     (rst),
        .busy    (w_busy),
        .clr_idx (w_clr_idx)
    );

    assign w_wen0 = we0 && (rd0 != ZERO_ADDR);
    assign w_wen1 = we1 && (rd1 != ZERO_ADDR);

    // Port 1 is written last so it wins when both ports target the same register.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[w_clr_idx] <= '0;
        end else begin
            if (w_wen0) begin
                r_mem[rd0] <= wd0;
            end
            if (w_wen1) begin
                r_mem[rd1] <= wd1;
            end
        end
    end

    assign w_rs[0] = rs1;
    assign w_rs[1] = rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [N-1:0] w_val;
            always_comb begin
                w_val = r_mem[w_rs[gi]];
`ifdef REGFILE_MP_BYPASS_EN
                if (w_wen0 && (rd0 == w_rs[gi])) begin
                    w_val = wd0;
                end
                if (w_wen1 && (rd1 == w_rs[gi])) begin
                    w_val = wd1;
                end
`endif
                if (w_busy || (w_rs[gi] == ZERO_ADDR)) begin
                    w_val = '0;
                end
            end
        end
    endgenerate

    assign read_data1 = g_rd[0].w_val;
    assign read_data2 = g_rd[1].w_val;
    assign busy       = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against an array-based reference model.
// Bypass expectations follow REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;

    localparam int N     = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1, rs2, rd0, rd1;
    logic [N-1:0]  wd0, wd1;
    logic          we0, we1;
    logic [N-1:0]  read_data1, read_data2;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: register contents plus the number of clear cycles still to run.
    logic [N-1:0] model [DEPTH];
    int           clear_left = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd0        (rd0),
        .rd1        (rd1),
        .wd0        (wd0),
        .wd1        (wd1),
        .we0        (we0),
        .we1        (we1),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .busy       (busy)
    );

    function automatic logic [N-1:0] exp_read(input logic [AW-1:0] a);
        if (clear_left > 0 || a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
        if (we1 && rd1 != 0 && rd1 == a) return wd1;
        if (we0 && rd0 != 0 && rd0 == a) return wd0;
`endif
        return model[a];
    endfunction

    // Advance one clock edge, applying the current inputs to the model first.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            clear_left = DEPTH - 1;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (we0 && rd0 != 0) model[rd0] = wd0;
            if (we1 && rd1 != 0) model[rd1] = wd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0;
        rd0 = '0; rd1 = '0; wd0 = '0; wd1 = '0;
        rs1 = '0; rs2 = '0;
    endtask

    // Pulse rst for one edge, then count busy cycles, checking reads stay zero.
    task automatic reset_and_count(input string tag, output int n_busy);
        logic [N-1:0] e1, e2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_busy = 0;
        while (busy === 1'b1 && n_busy < 3 * DEPTH) begin
            rs1 = AW'($urandom);
            rs2 = AW'($urandom);
            #1;
            e1 = exp_read(rs1);
            e2 = exp_read(rs2);
            n_cmp++;
            if (read_data1 !== e1 || read_data2 !== e2) begin
                n_fail++;
                $display("FAIL %s_clear_read: rd1=%h rd2=%h required %h %h", tag, read_data1, read_data2, e1, e2);
            end
            tick();
            n_busy++;
        end
        n_cmp++;
        if (n_busy !== DEPTH - 1) begin
            n_fail++;
            $display("FAIL %s_busy_len: got %0d cycles required %0d", tag, n_busy, DEPTH - 1);
        end
        $display("%s: busy lasted %0d cycles", tag, n_busy);
    endtask

    task automatic test_reset();
        int nb;
        idle();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b required 1", busy);
        end
        reset_and_count("reset", nb);
        for (int i = 0; i < DEPTH; i++) begin
            rs1 = AW'(i);
            rs2 = AW'(DEPTH - 1 - i);
            #1;
            n_cmp++;
            if (read_data1 !== '0 || read_data2 !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_zero[%0d]: rd1=%h rd2=%h busy=%b required 0 0 0", i, read_data1, read_data2, busy);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        we0 = 1'b1; rd0 = AW'(5); wd0 = 32'hDEADBEEF;
        tick();
        idle();
        rs1 = AW'(5);
        #1;
        n_cmp++;
        if (read_data1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_reg5: got %h required deadbeef", read_data1);
        end
        $display("write_read: reg5 = %h", read_data1);
        we0 = 1'b1; rd0 = '0; wd0 = 32'h1234;
        tick();
        idle();
        #1;
        n_cmp++;
        if (read_data1 !== '0) begin
            n_fail++;
            $display("FAIL write_reg0: got %h required 0", read_data1);
        end
        $display("write_read: reg0 = %h", read_data1);
    endtask

    task automatic test_same_addr();
        idle();
        we0 = 1'b1; we1 = 1'b1; rd0 = AW'(7); rd1 = AW'(7);
        wd0 = 32'h11; wd1 = 32'h22;
        tick();
        idle();
        rs1 = AW'(7);
        #1;
        n_cmp++;
        if (read_data1 !== 32'h22) begin
            n_fail++;
            $display("FAIL same_addr: got %h required 22", read_data1);
        end
        $display("same_addr: reg7 = %h", read_data1);
    endtask

    task automatic test_bypass();
        logic [N-1:0] exp;
        idle();
        we0 = 1'b1; rd0 = AW'(3); wd0 = 32'hAA;
        tick();
        idle();
        we1 = 1'b1; rd1 = AW'(3); wd1 = 32'h55; rs2 = AW'(3);
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        exp = 32'h55;
`else
        exp = 32'hAA;
`endif
        n_cmp++;
        if (read_data2 !== exp) begin
            n_fail++;
            $display("FAIL bypass: got %h required %h", read_data2, exp);
        end
        $display("bypass: read_data2 = %h", read_data2);
        tick();
        idle();
        rs2 = AW'(3);
        #1;
        n_cmp++;
        if (read_data2 !== 32'h55) begin
            n_fail++;
            $display("FAIL bypass_commit: got %h required 55", read_data2);
        end
    endtask

    task automatic test_reset_midclear();
        int nb;
        idle();
        we0 = 1'b1; rd0 = AW'(4); wd0 = 32'hCAFE0004;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_busy: got %b required 1", busy);
        end
        we0 = 1'b1; rd0 = AW'(4); wd0 = 32'h0BAD0004;
        reset_and_count("midclear", nb);
        idle();
        rs1 = AW'(4);
        #1;
        n_cmp++;
        if (read_data1 !== '0) begin
            n_fail++;
            $display("FAIL midclear_reg4: got %h required 0", read_data1);
        end
    endtask

    task automatic test_reset_ready();
        int nb;
        idle();
        we1 = 1'b1; rd1 = AW'(9); wd1 = 32'h77;
        tick();
        idle();
        rs1 = AW'(9);
        #1;
        n_cmp++;
        if (read_data1 !== 32'h77) begin
            n_fail++;
            $display("FAIL ready_reg9_pre: got %h required 77", read_data1);
        end
        reset_and_count("ready_rst", nb);
        idle();
        rs1 = AW'(9);
        #1;
        n_cmp++;
        if (read_data1 !== '0) begin
            n_fail++;
            $display("FAIL ready_reg9_post: got %h required 0", read_data1);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] e1, e2;
        logic         eb;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            we0 = $urandom_range(0, 1);
            we1 = $urandom_range(0, 1);
            rd0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rd1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rs1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rs2 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd0 = $urandom;
            wd1 = $urandom;
            #1;
            e1 = exp_read(rs1);
            e2 = exp_read(rs2);
            eb = (clear_left > 0);
            n_cmp++;
            if (read_data1 !== e1 || read_data2 !== e2 || busy !== eb) begin
                n_fail++;
                $display("FAIL random[%0d]: rd1=%h rd2=%h busy=%b required %h %h %b",
                         c, read_data1, read_data2, busy, e1, e2, eb);
            end
            tick();
        end
        $display("random: 600 cycles checked");
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_same_addr();
        test_bypass();
        test_reset_midclear();
        test_reset_ready();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
